// File: rtl/kb_event_if.sv
// Bundles the byte-receiver input, the consumer pop/clear controls and the
// head-of-queue event outputs of the key-event decoder.
// Ports: slave = decoder side, master = producer/consumer side.
interface kb_event_if;
  logic       rx_done_tick;  // one-cycle strobe, rx_data valid
  logic [7:0] rx_data;       // received scan byte
  logic       rd_key_code;   // pop head event
  logic       clr_ovf;       // clear sticky overflow
  logic [7:0] key_code;      // head event scan code
  logic       key_ext;       // head event had E0 prefix
  logic       key_brk;       // head event is a release
  logic       kb_buf_empty;
  logic       kb_buf_full;
  logic       overflow;      // sticky: an event was dropped

  modport slave (
    input  rx_done_tick, rx_data, rd_key_code, clr_ovf,
    output key_code, key_ext, key_brk, kb_buf_empty, kb_buf_full, overflow
  );

  modport master (
    output rx_done_tick, rx_data, rd_key_code, clr_ovf,
    input  key_code, key_ext, key_brk, kb_buf_empty, kb_buf_full, overflow
  );
endinterface

// File: rtl/kb_event.sv
// PS/2 set-2 scan-code decoder: turns E0/F0/E1-prefixed byte sequences into
// {brk, ext, code} events, optionally filters typematic repeats, and queues
// them in a first-word-fall-through FIFO with sticky overflow.
// Ports: clk, reset_n (async active-low), kb (slave: rx byte strobe in,
// pop/clear in, head event + empty/full/overflow out).
module kb_event #(
  parameter int W_SIZE        = 2,
  parameter int MODE          = 1,
  parameter int REPEAT_FILTER = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  kb_event_if.slave kb
);

  localparam int DEPTH = 1 << W_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_PAUSE} state_t;

  state_t      state_q, state_d;
  logic        ext_q, ext_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        lm_vld_q, lm_vld_d;
  logic [8:0]  lm_q, lm_d;          // last make {ext, code}

  logic        ev_vld, ev_brk, ev_ext;
  logic [7:0]  ev_code;
  logic        lm_match;
  logic        wr_req;

  logic [9:0]        mem_q [DEPTH];
  logic [W_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W_SIZE-1:0] wr_ptr_inc, rd_ptr_inc;
  logic              empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic              rd_en, wr_en, drop;

  // ---------------------------------------------------------------- decoder
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;
    ev_vld  = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    ev_code = kb.rx_data;
    if (kb.rx_done_tick) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (kb.rx_data)
            8'hE0: state_d = S_EXT;
            8'hF0: begin
              state_d = S_BRK;
              ext_d   = 1'b0;
            end
            8'hE1: begin
              state_d = S_PAUSE;
              cnt_d   = 3'd7;
            end
            // keyboard responses (ACK, BAT, echo, resend, errors)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: ev_vld = 1'b1;
          endcase
        end
        S_EXT: begin
          unique case (kb.rx_data)
            8'hF0: begin
              state_d = S_BRK;
              ext_d   = 1'b1;
            end
            8'hE0: ;
            // fake shifts wrapped around extended keys carry no key info
            8'h12, 8'h59: state_d = S_IDLE;
            default: begin
              ev_vld  = 1'b1;
              ev_ext  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          ev_vld  = 1'b1;
          ev_brk  = 1'b1;
          ev_ext  = ext_q;
          ext_d   = 1'b0;
          state_d = S_IDLE;
        end
        S_PAUSE: begin
          cnt_d = cnt_q - 3'd1;
          // Pause is an 8-byte make with no release; report it once as E1
          if (cnt_q == 3'd1) begin
            ev_vld  = 1'b1;
            ev_code = 8'hE1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------- repeat filter / mode
  assign lm_match = lm_vld_q && (lm_q == {ev_ext, ev_code});

  always_comb begin
    wr_req   = 1'b0;
    lm_vld_d = lm_vld_q;
    lm_d     = lm_q;
    if (ev_vld) begin
      if (ev_brk) begin
        wr_req = 1'b1;
        if (REPEAT_FILTER != 0 && lm_match) lm_vld_d = 1'b0;
      end else if (!(REPEAT_FILTER != 0 && lm_match)) begin
        wr_req = (MODE != 0);
        // held-key tracking follows decoded makes even when they are not queued
        if (REPEAT_FILTER != 0) begin
          lm_d     = {ev_ext, ev_code};
          lm_vld_d = 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------- FIFO
  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;
  assign rd_en      = kb.rd_key_code && !empty_q;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en      = wr_req && (!full_q || rd_en);
  assign drop       = wr_req && full_q && !rd_en;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_inc : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_inc : rd_ptr_q;
    empty_d  = empty_q;
    full_d   = full_q;
    if (wr_en && !rd_en) begin
      empty_d = 1'b0;
      full_d  = (wr_ptr_inc == rd_ptr_q);
    end else if (rd_en && !wr_en) begin
      full_d  = 1'b0;
      empty_d = (rd_ptr_inc == wr_ptr_q);
    end
    ovf_d = drop ? 1'b1 : (kb.clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ext_q    <= 1'b0;
      cnt_q    <= '0;
      lm_vld_q <= 1'b0;
      lm_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_d;
      cnt_q    <= cnt_d;
      lm_vld_q <= lm_vld_d;
      lm_q     <= lm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      if (wr_en) mem_q[wr_ptr_q] <= {ev_brk, ev_ext, ev_code};
    end
  end

  assign kb.key_brk      = mem_q[rd_ptr_q][9];
  assign kb.key_ext      = mem_q[rd_ptr_q][8];
  assign kb.key_code     = mem_q[rd_ptr_q][7:0];
  assign kb.kb_buf_empty = empty_q;
  assign kb.kb_buf_full  = full_q;
  assign kb.overflow     = ovf_q;

endmodule

// File: tb/tb_kb_event.sv
// Bench for kb_event: three instances (MODE/REPEAT_FILTER = 1/1, 1/0, 0/1)
// share one byte stream and are compared every cycle against a sequence-level
// decoder model feeding shift-list FIFO models.
module tb_kb_event;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kb_event_if ifa();
  kb_event_if ifb();
  kb_event_if ifc();

  kb_event #(.W_SIZE(2), .MODE(1), .REPEAT_FILTER(1)) dut_a (.clk(clk), .reset_n(reset_n), .kb(ifa));
  kb_event #(.W_SIZE(2), .MODE(1), .REPEAT_FILTER(0)) dut_b (.clk(clk), .reset_n(reset_n), .kb(ifb));
  kb_event #(.W_SIZE(2), .MODE(0), .REPEAT_FILTER(1)) dut_c (.clk(clk), .reset_n(reset_n), .kb(ifc));

  // {overflow, full, empty, brk, ext, code}
  logic [12:0] obs [3];
  always_comb begin
    obs[0] = {ifa.overflow, ifa.kb_buf_full, ifa.kb_buf_empty, ifa.key_brk, ifa.key_ext, ifa.key_code};
    obs[1] = {ifb.overflow, ifb.kb_buf_full, ifb.kb_buf_empty, ifb.key_brk, ifb.key_ext, ifb.key_code};
    obs[2] = {ifc.overflow, ifc.kb_buf_full, ifc.kb_buf_empty, ifc.key_brk, ifc.key_ext, ifc.key_code};
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  localparam int CAP = 4;
  bit          mode_p [3] = '{1'b1, 1'b1, 1'b0};
  bit          rf_p   [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0]  seq [$];          // bytes of the sequence in progress
  logic [9:0]  mq [3][CAP];      // queued events, index 0 = head
  int          mcnt [3];
  bit          movf [3];
  bit          lm_v [3];
  logic [8:0]  lm   [3];

  function automatic void model_reset();
    seq.delete();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; movf[k] = 1'b0; lm_v[k] = 1'b0; lm[k] = '0;
    end
  endfunction

  function automatic bit is_resp(logic [7:0] b);
    return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
  endfunction

  function automatic void model_cycle(bit tick, logic [7:0] b, bit rd, bit clr);
    bit ev = 1'b0, eb = 1'b0, ee = 1'b0;
    logic [7:0] ec = b;
    if (tick) begin
      if (seq.size() > 0 && seq[0] == 8'hE1) begin
        seq.push_back(b);
        if (seq.size() == 8) begin ev = 1'b1; ec = 8'hE1; seq.delete(); end
      end else if (seq.size() > 0 && seq[seq.size()-1] == 8'hF0) begin
        ev = 1'b1; eb = 1'b1;
        foreach (seq[i]) if (seq[i] == 8'hE0) ee = 1'b1;
        seq.delete();
      end else if (seq.size() > 0) begin
        // prefix so far is E0 only
        if (b == 8'hF0) seq.push_back(b);
        else if (b == 8'hE0) ;
        else if (b == 8'h12 || b == 8'h59) seq.delete();
        else begin ev = 1'b1; ee = 1'b1; seq.delete(); end
      end else begin
        if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) seq.push_back(b);
        else if (!is_resp(b)) ev = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      bit wr = 1'b0, match, drop = 1'b0;
      if (ev) begin
        match = lm_v[k] && (lm[k] == {ee, ec});
        if (eb) begin
          wr = 1'b1;
          if (rf_p[k] && match) lm_v[k] = 1'b0;
        end else if (!(rf_p[k] && match)) begin
          wr = mode_p[k];
          if (rf_p[k]) begin lm[k] = {ee, ec}; lm_v[k] = 1'b1; end
        end
      end
      if (rd && mcnt[k] > 0) begin
        for (int i = 0; i < CAP - 1; i++) mq[k][i] = mq[k][i+1];
        mcnt[k]--;
      end
      if (wr) begin
        if (mcnt[k] < CAP) begin mq[k][mcnt[k]] = {eb, ee, ec}; mcnt[k]++; end
        else drop = 1'b1;
      end
      if (drop) movf[k] = 1'b1;
      else if (clr) movf[k] = 1'b0;
    end
  endfunction

  // ------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("empty", k, obs[k][10], mcnt[k] == 0);
        chk("full", k, obs[k][11], mcnt[k] == CAP);
        chk("overflow", k, obs[k][12], movf[k]);
        if (mcnt[k] > 0) chk("head", k, obs[k][9:0], mq[k][0]);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic cyc(bit tick, logic [7:0] b, bit rd, bit clr);
    ifa.rx_done_tick = tick; ifb.rx_done_tick = tick; ifc.rx_done_tick = tick;
    ifa.rx_data = b;         ifb.rx_data = b;         ifc.rx_data = b;
    ifa.rd_key_code = rd;    ifb.rd_key_code = rd;    ifc.rd_key_code = rd;
    ifa.clr_ovf = clr;       ifb.clr_ovf = clr;       ifc.clr_ovf = clr;
    @(posedge clk);
    if (reset_n) model_cycle(tick, b, rd, clr);
    @(negedge clk);
  endtask

  task automatic send(logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
    repeat ($urandom_range(0, 1)) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] tbl [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hFA,
                           8'h1C, 8'h1D, 8'h75, 8'h77, 8'h14, 8'h00};

  initial begin
    ifa.rx_done_tick = 0; ifb.rx_done_tick = 0; ifc.rx_done_tick = 0;
    ifa.rx_data = 0; ifb.rx_data = 0; ifc.rx_data = 0;
    ifa.rd_key_code = 0; ifb.rd_key_code = 0; ifc.rd_key_code = 0;
    ifa.clr_ovf = 0; ifb.clr_ovf = 0; ifc.clr_ovf = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", 0, ifa.kb_buf_empty, 1'b1);
    chk("rst_full", 0, ifa.kb_buf_full, 1'b0);
    chk("rst_ovf", 0, ifa.overflow, 1'b0);
    chk("rst_head", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h000);
    chk_en = 1'b1;

    // make then break; empty falls one cycle after the tick
    cyc(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("wr_latency", 0, ifa.kb_buf_empty, 1'b0);
    chk("make_head", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h01C);
    send(8'hF0); send(8'h1C);
    chk("mode0_head", 2, {ifc.key_brk, ifc.key_ext, ifc.key_code}, 10'h21C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("break_head", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h21C);
    chk("mode0_empty", 2, ifc.kb_buf_empty, 1'b1);
    drain();

    // extended make/break with fake shift
    send(8'hE0); send(8'h75);
    chk("ext_make", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h175);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    // typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    chk("rep_filt_full", 0, ifa.kb_buf_full, 1'b0);
    chk("rep_pass_full", 1, ifb.kb_buf_full, 1'b1);
    drain();
    send(8'h1C);
    drain();

    // pause sequence then keyboard responses
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_head", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h0E1);
    send(8'hFA); send(8'hAA);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pause_single", 0, ifa.kb_buf_empty, 1'b1);
    drain();

    // overflow
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("ovf_set", 0, ifa.overflow, 1'b1);
    chk("ovf_full", 0, ifa.kb_buf_full, 1'b1);
    chk("ovf_head", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h015);
    cyc(1'b1, 8'h35, 1'b1, 1'b0);
    chk("rdwr_full", 0, ifa.kb_buf_full, 1'b1);
    chk("rdwr_head", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h01D);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 0, ifa.overflow, 1'b0);
    drain();

    // reset in the middle of a break sequence
    send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("rst_abort", 0, {ifa.key_brk, ifa.key_ext, ifa.key_code}, 10'h01C);
    drain();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else b = tbl[$urandom_range(0, 11)];
      if ($urandom_range(0, 799) == 0) do_reset();
      cyc($urandom_range(0, 2) == 0, b, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
